vector_checker: RTL and testbench

Synthesizable, parametrised self-checking test-vector engine for on-FPGA verification of Hack datapath blocks (ALU, CPU slices). It walks a vector ROM and drives each vector's stimulus into a device under test. It then waits a configurable response latency and compares the DUT response against the expected value under a per-vector don't-care mask, accumulating pass/fail status for a host or LED readout.

---
 rtl/vector_checker_pkg.sv | 31 +++
 rtl/vector_checker.sv | 161 ++++++++++++++++
 tb/tb_vector_checker.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_checker_pkg.sv
// Shared types and constants for the vector_checker test-vector engine.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package vector_checker_pkg;

  // Sequencer states; one vector walks FETCH -> APPLY -> [SETTLE] -> CHECK.
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  // rom_data layout is {stim, exp, mask}, with mask in the low bits. The
  // upper offsets depend on the response width, so they are computed from it.
  localparam int MASK_LSB = 0;

  function automatic int exp_lsb(input int resp_w);
    return resp_w;
  endfunction

  function automatic int stim_lsb(input int resp_w);
    return 2 * resp_w;
  endfunction

  // error_count sticks here instead of wrapping back to zero.
  localparam logic [31:0] ERR_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/vector_checker.sv
// Walks a vector ROM, drives stim into a DUT, compares its response under a mask.
// Latency: NUM_VECTORS*(3+LATENCY) cycles from the start-sampling edge to done.
// Backpressure: none; start is only honoured in IDLE or DONE, ignored while busy.
//
// Ports:
//   clk, reset (async, active-high)  start: begin a run from IDLE/DONE
//   rom_addr/rom_data                 : synchronous ROM, 1-cycle read, word {stim, exp, mask}
//   stim/resp                         : registered stimulus out, DUT response in
//   busy, done, pass, mismatch        : run status; mismatch pulses in a failing CHECK cycle
//   error_count, first_err_idx, first_err_got, vec_idx : result readout
module vector_checker
  import vector_checker_pkg::*;
#(
  parameter int STIM_W      = 22,
  parameter int RESP_W      = 18,
  parameter int NUM_VECTORS = 18000,
  parameter int ADDR_W      = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1,
  parameter int LATENCY     = 0,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [STIM_W+2*RESP_W-1:0] rom_data,
  output logic [STIM_W-1:0]          stim,
  input  logic [RESP_W-1:0]          resp,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       mismatch,
  output logic [31:0]                error_count,
  output logic [ADDR_W-1:0]          first_err_idx,
  output logic [RESP_W-1:0]          first_err_got,
  output logic [ADDR_W-1:0]          vec_idx
);

  localparam int ROM_W   = STIM_W + 2 * RESP_W;
  localparam int STIM_LO = stim_lsb(RESP_W);
  localparam int EXP_LO  = exp_lsb(RESP_W);
  // Keep the settle counter at least one bit wide so LATENCY=0 still elaborates.
  localparam int CNT_W   = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VECTORS - 1);

  state_e              state_q, state_d;
  logic [STIM_W-1:0]   stim_q, stim_d;
  logic [RESP_W-1:0]   exp_q, exp_d;
  logic [RESP_W-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]   vec_idx_q, vec_idx_d;
  logic [31:0]         err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   first_idx_q, first_idx_d;
  logic [RESP_W-1:0]   first_got_q, first_got_d;
  logic                fail;

  // Only bits with mask=1 take part; an all-zero mask can never fail.
  assign fail = |((resp ^ exp_q) & mask_q);

  always_comb begin
    state_d     = state_q;
    stim_d      = stim_q;
    exp_d       = exp_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    rom_addr_d  = rom_addr_q;
    vec_idx_d   = vec_idx_q;
    err_cnt_d   = err_cnt_q;
    first_idx_d = first_idx_q;
    first_got_d = first_got_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          err_cnt_d   = '0;
          first_idx_d = '1;
          first_got_d = '0;
          vec_idx_d   = '0;
          rom_addr_d  = '0;
          state_d     = S_FETCH;
        end
      end
      // rom_addr is already presented; the ROM returns the word next cycle.
      S_FETCH: state_d = S_APPLY;
      S_APPLY: begin
        stim_d = rom_data[ROM_W-1:STIM_LO];
        exp_d  = rom_data[STIM_LO-1:EXP_LO];
        mask_d = rom_data[EXP_LO-1:MASK_LSB];
        if (LATENCY > 0) begin
          cnt_d   = CNT_W'(LATENCY);
          state_d = S_SETTLE;
        end else begin
          state_d = S_CHECK;
        end
      end
      // Leaves on the cycle the counter would hit zero: exactly LATENCY cycles here.
      S_SETTLE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (fail) begin
          if (err_cnt_q != ERR_CNT_MAX) err_cnt_d = err_cnt_q + 32'd1;
          // A zero count means this is the first failure of the run; first_idx
          // cannot serve as the marker because all-ones is also a valid index.
          if (err_cnt_q == '0) begin
            first_idx_d = vec_idx_q;
            first_got_d = resp;
          end
        end
        if (vec_idx_q == LAST_IDX || (STOP_ON_ERR != 0 && fail)) begin
          state_d = S_DONE;
        end else begin
          vec_idx_d  = vec_idx_q + 1'b1;
          rom_addr_d = vec_idx_q + 1'b1;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      stim_q      <= '0;
      exp_q       <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      rom_addr_q  <= '0;
      vec_idx_q   <= '0;
      err_cnt_q   <= '0;
      first_idx_q <= '1;
      first_got_q <= '0;
    end else begin
      state_q     <= state_d;
      stim_q      <= stim_d;
      exp_q       <= exp_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      rom_addr_q  <= rom_addr_d;
      vec_idx_q   <= vec_idx_d;
      err_cnt_q   <= err_cnt_d;
      first_idx_q <= first_idx_d;
      first_got_q <= first_got_d;
    end
  end

  // Status is decoded from the state register so reset clears it immediately.
  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign pass          = (state_q == S_DONE) && (err_cnt_q == '0);
  assign mismatch      = (state_q == S_CHECK) && fail;
  assign stim          = stim_q;
  assign rom_addr      = rom_addr_q;
  assign vec_idx       = vec_idx_q;
  assign error_count   = err_cnt_q;
  assign first_err_idx = first_idx_q;
  assign first_err_got = first_got_q;

endmodule

// File: tb/tb_vector_checker.sv
// Bench for vector_checker: three instances (LAT0, LAT0+STOP_ON_ERR, LAT2) share one ROM image.
// Latency: checked against NUM_VECTORS*(3+LATENCY) and the spec's per-vector CHECK timing.
// Backpressure: start pulses while busy or in the final CHECK must be ignored.
module tb_vector_checker;

  logic        clk;
  logic        reset;
  logic        start_w [3];
  logic [1:0]  addr_w [3];
  logic [11:0] rdat_w [3];
  logic [3:0]  stim_w [3];
  logic [3:0]  resp_w [3];
  logic        busy_w [3];
  logic        done_w [3];
  logic        pass_w [3];
  logic        mis_w [3];
  logic [31:0] err_w [3];
  logic [1:0]  fidx_w [3];
  logic [3:0]  fgot_w [3];
  logic [1:0]  vidx_w [3];
  logic [3:0]  p1 [3];
  logic [3:0]  p2 [3];
  logic        use_pipe [3];
  logic [11:0] rom_mem [4];

  int checks = 0;
  int errors = 0;

  // Instance 0: LATENCY=0; instance 1: LATENCY=0, STOP_ON_ERR=1; instance 2: LATENCY=2.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    vector_checker #(
      .STIM_W(4), .RESP_W(4), .NUM_VECTORS(4),
      .LATENCY((g == 2) ? 2 : 0), .STOP_ON_ERR((g == 1) ? 1 : 0)
    ) u_dut (
      .clk(clk), .reset(reset), .start(start_w[g]),
      .rom_addr(addr_w[g]), .rom_data(rdat_w[g]),
      .stim(stim_w[g]), .resp(resp_w[g]),
      .busy(busy_w[g]), .done(done_w[g]), .pass(pass_w[g]), .mismatch(mis_w[g]),
      .error_count(err_w[g]), .first_err_idx(fidx_w[g]),
      .first_err_got(fgot_w[g]), .vec_idx(vidx_w[g])
    );
  end

  always #5 clk = ~clk;

  // Synchronous ROMs and the two-stage registered DUT copies.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      rdat_w[i] <= rom_mem[addr_w[i]];
      p1[i]     <= stim_w[i];
      p2[i]     <= p1[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) resp_w[i] = use_pipe[i] ? ~p2[i] : ~stim_w[i];
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic chk_reset(input int c, input string tag);
    chk({tag, "_stim"}, 32'(stim_w[c]), 0);
    chk({tag, "_rom_addr"}, 32'(addr_w[c]), 0);
    chk({tag, "_vec_idx"}, 32'(vidx_w[c]), 0);
    chk({tag, "_err"}, err_w[c], 0);
    chk({tag, "_fgot"}, 32'(fgot_w[c]), 0);
    chk({tag, "_fidx"}, 32'(fidx_w[c]), 3);
    chk({tag, "_busy"}, 32'(busy_w[c]), 0);
    chk({tag, "_done"}, 32'(done_w[c]), 0);
    chk({tag, "_pass"}, 32'(pass_w[c]), 0);
    chk({tag, "_mismatch"}, 32'(mis_w[c]), 0);
  endtask

  // Pulses start on instance c and counts cycles (0 = first cycle after the
  // start-sampling edge) until done. Optionally re-pulses start at cycle restart_at.
  task automatic run(input int c, input logic [47:0] rom, input int restart_at,
                     output int lat, output int npulse, output int first_pulse);
    for (int i = 0; i < 4; i++) rom_mem[i] = rom[i*12 +: 12];
    @(negedge clk); start_w[c] = 1'b1;
    @(negedge clk); start_w[c] = 1'b0;
    lat = 0; npulse = 0; first_pulse = -1;
    while (!done_w[c] && lat < 200) begin
      if (mis_w[c]) begin
        npulse++;
        if (first_pulse < 0) first_pulse = lat;
      end
      start_w[c] = (lat == restart_at);
      @(negedge clk); lat++;
    end
    start_w[c] = 1'b0;
  endtask

  // Reference: evaluates the vector list directly with resp = ~stim.
  function automatic void model(input logic [47:0] rom, input bit stop, input int latency,
                                output int lat, output int errs, output int fidx,
                                output int fgot, output int vidx, output int pulse_at);
    errs = 0; fidx = 3; fgot = 0; vidx = 0; pulse_at = -1;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] s, e, m, r;
      {s, e, m} = rom[k*12 +: 12];
      r = ~s;
      vidx = k;
      if (((r ^ e) & m) != 4'h0) begin
        if (errs == 0) begin
          fidx = k; fgot = int'(r); pulse_at = k * (3 + latency) + 2 + latency;
        end
        errs++;
        if (stop) break;
      end
    end
    lat = (vidx + 1) * (3 + latency);
  endfunction

  typedef struct packed {
    int          cfg;
    logic [47:0] rom;
    int          lat;
    int          errs;
    int          fidx;
    int          fgot;
    int          pass;
    int          vidx;
    int          pulse_at;
  } vec_t;

  localparam logic [47:0] ALL_PASS = {12'h3CF, 12'h2DF, 12'h1EF, 12'h0FF};

  vec_t tbl [5];

  initial begin
    int lat, np, fp;
    int m_lat, m_errs, m_fidx, m_fgot, m_vidx, m_pulse;
    logic [47:0] rom;
    string nm;

    clk = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_w[i] = 1'b0;
      use_pipe[i] = (i == 2);
    end
    for (int i = 0; i < 4; i++) rom_mem[i] = 12'h0;

    tbl[0] = '{cfg:0, rom:ALL_PASS, lat:12, errs:0, fidx:3, fgot:0, pass:1, vidx:3, pulse_at:-1};
    tbl[1] = '{cfg:0, rom:{12'h3CF, 12'h20F, 12'h1EF, 12'h0FF},
               lat:12, errs:1, fidx:2, fgot:13, pass:0, vidx:3, pulse_at:8};
    tbl[2] = '{cfg:0, rom:{12'h3CF, 12'h2DF, 12'h123, 12'h0FF},
               lat:12, errs:0, fidx:3, fgot:0, pass:1, vidx:3, pulse_at:-1};
    tbl[3] = '{cfg:1, rom:{12'h30F, 12'h2DF, 12'h10F, 12'h0FF},
               lat:6, errs:1, fidx:1, fgot:14, pass:0, vidx:1, pulse_at:5};
    tbl[4] = '{cfg:2, rom:ALL_PASS, lat:20, errs:0, fidx:3, fgot:0, pass:1, vidx:3, pulse_at:-1};

    repeat (2) @(negedge clk);
    chk_reset(0, "rst0");
    chk_reset(2, "rst2");
    reset = 1'b0;

    // Directed table.
    for (int t = 0; t < 5; t++) begin
      run(tbl[t].cfg, tbl[t].rom, -1, lat, np, fp);
      nm = $sformatf("tbl%0d", t);
      chk({nm, "_latency"}, lat, tbl[t].lat);
      chk({nm, "_errs"}, err_w[tbl[t].cfg], tbl[t].errs);
      chk({nm, "_fidx"}, 32'(fidx_w[tbl[t].cfg]), tbl[t].fidx);
      chk({nm, "_fgot"}, 32'(fgot_w[tbl[t].cfg]), tbl[t].fgot);
      chk({nm, "_pass"}, 32'(pass_w[tbl[t].cfg]), tbl[t].pass);
      chk({nm, "_vidx"}, 32'(vidx_w[tbl[t].cfg]), tbl[t].vidx);
      chk({nm, "_npulse"}, np, tbl[t].errs);
      chk({nm, "_pulse_at"}, fp, tbl[t].pulse_at);
    end

    // start while busy, and start in the final CHECK cycle: both ignored.
    run(0, ALL_PASS, 4, lat, np, fp);
    chk("busy_start_latency", lat, 12);
    chk("busy_start_pass", 32'(pass_w[0]), 1);
    run(0, ALL_PASS, 11, lat, np, fp);
    chk("last_check_start_latency", lat, 12);
    @(negedge clk);
    chk("last_check_start_still_done", 32'(done_w[0]), 1);
    chk("last_check_start_not_busy", 32'(busy_w[0]), 0);

    // Registered DUT without settle cycles samples stale responses.
    use_pipe[0] = 1'b1;
    run(0, ALL_PASS, -1, lat, np, fp);
    chk("pipe_lat0_pass", 32'(pass_w[0]), 0);
    checks++;
    if (err_w[0] < 3) begin
      errors++;
      $display("FAIL pipe_lat0_errs got %0d want at least 3", err_w[0]);
    end
    use_pipe[0] = 1'b0;

    // Reset during vector 2's SETTLE on the LATENCY=2 instance; vector 0 fails.
    for (int i = 0; i < 4; i++) rom_mem[i] = ALL_PASS[i*12 +: 12];
    rom_mem[0] = 12'h50F;
    @(negedge clk); start_w[2] = 1'b1;
    @(negedge clk); start_w[2] = 1'b0;
    repeat (12) @(negedge clk);
    chk("pre_reset_busy", 32'(busy_w[2]), 1);
    chk("pre_reset_errs", err_w[2], 1);
    chk("pre_reset_stim", 32'(stim_w[2]), 2);
    reset = 1'b1;
    #1;
    chk_reset(2, "midrst");
    @(negedge clk); reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_reset_idle_busy", 32'(busy_w[2]), 0);
    chk("post_reset_idle_done", 32'(done_w[2]), 0);
    run(2, ALL_PASS, -1, lat, np, fp);
    chk("post_reset_latency", lat, 20);
    chk("post_reset_pass", 32'(pass_w[2]), 1);
    chk("post_reset_errs", err_w[2], 0);

    // Randomized vectors against the reference model.
    for (int it = 0; it < 24; it++) begin
      int c;
      c = $urandom_range(0, 2);
      for (int k = 0; k < 4; k++) begin
        logic [3:0] s, e, m, flip;
        s = 4'($urandom_range(0, 15));
        flip = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        e = ~s ^ flip;
        m = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        rom[k*12 +: 12] = {s, e, m};
      end
      model(rom, c == 1, (c == 2) ? 2 : 0, m_lat, m_errs, m_fidx, m_fgot, m_vidx, m_pulse);
      run(c, rom, -1, lat, np, fp);
      nm = $sformatf("rnd%0d_c%0d", it, c);
      chk({nm, "_latency"}, lat, m_lat);
      chk({nm, "_errs"}, err_w[c], m_errs);
      chk({nm, "_fidx"}, 32'(fidx_w[c]), m_fidx);
      chk({nm, "_fgot"}, 32'(fgot_w[c]), m_fgot);
      chk({nm, "_pass"}, 32'(pass_w[c]), (m_errs == 0) ? 1 : 0);
      chk({nm, "_vidx"}, 32'(vidx_w[c]), m_vidx);
      chk({nm, "_npulse"}, np, m_errs);
      chk({nm, "_pulse_at"}, fp, m_pulse);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
